// File: rtl/serial_alu_seq.sv
// Bit-serial INC/DEC/ADD/SUB sequencer, LSB-first, one bit per clock; ovf logic under SERIAL_ALU_SEQ_OVF_EN.
// Latency: out_valid rises WIDTH edges after the accept edge; best throughput one op per WIDTH+2 cycles.
// Backpressure: in_ready only in IDLE; DONE holds result and flags until out_ready.
module serial_alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero,
  output logic             ovf,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [1:0] OP_INC = 2'b00;
  localparam logic [1:0] OP_DEC = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SUB = 2'b11;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [CW-1:0]    cnt;
  logic             c;
  logic [1:0]       op_q;

  logic             a_i;
  logic             b_i;
  logic             sum;
  logic             c_nxt;
  logic             last;
  logic [WIDTH-1:0] res_nxt;

  always_comb begin
    a_i = sa[0];
    b_i = 1'b0;
    case (op_q)
      OP_INC: b_i = 1'b0;
      OP_DEC: b_i = 1'b1;
      OP_ADD: b_i = sb[0];
      OP_SUB: b_i = ~sb[0];
      default: b_i = 1'b0;
    endcase
    sum     = a_i ^ b_i ^ c;
    c_nxt   = (a_i & b_i) | (a_i & c) | (b_i & c);
    last    = (cnt == CW'(WIDTH - 1));
    res_nxt = {sum, result[WIDTH-1:1]};
  end

  assign in_ready  = (state == IDLE) & rst_n;
  assign out_valid = (state == DONE);
  assign busy      = (state == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      sa     <= '0;
      sb     <= '0;
      cnt    <= '0;
      c      <= 1'b0;
      op_q   <= OP_INC;
      result <= '0;
      cout   <= 1'b0;
      zero   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state <= RUN;
            sa    <= a;
            sb    <= b;
            op_q  <= op;
            cnt   <= '0;
            // Carry-in of 1 turns INC into +1 and SUB into a + ~b + 1.
            c     <= (op == OP_INC) || (op == OP_SUB);
          end
        end
        RUN: begin
          sa     <= sa >> 1;
          sb     <= sb >> 1;
          result <= res_nxt;
          cnt    <= cnt + 1'b1;
          c      <= c_nxt;
          if (last) begin
            state <= DONE;
            cout  <= c_nxt;
            zero  <= (res_nxt == '0);
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SERIAL_ALU_SEQ_OVF_EN
  // On the last bit the carry register still holds the carry into the MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (state == RUN && last) begin
      ovf <= c ^ c_nxt;
    end
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_alu_seq.sv
// Directed and random self-checking bench for serial_alu_seq at WIDTH=8.
module tb_serial_alu_seq;
  localparam int W = 8;
`ifdef SERIAL_ALU_SEQ_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         cout;
  logic         zero;
  logic         ovf;
  logic         busy;

  int checks = 0;
  int errors = 0;

  serial_alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .cout(cout), .zero(zero), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: full-width add of a, the effective B operand and carry-in.
  function automatic logic [W+2:0] model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] bb;
    logic         ci;
    logic [W:0]   s;
    logic         ov;
    case (o)
      2'b00:   begin bb = '0; ci = 1'b1; end
      2'b01:   begin bb = '1; ci = 1'b0; end
      2'b10:   begin bb = y;  ci = 1'b0; end
      default: begin bb = ~y; ci = 1'b1; end
    endcase
    s  = {1'b0, x} + {1'b0, bb} + {{W{1'b0}}, ci};
    ov = (x[W-1] == bb[W-1]) && (s[W-1] != x[W-1]) && OVF_ON;
    return {ov, (s[W-1:0] == '0), s[W], s[W-1:0]};
  endfunction

  task automatic start(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) chk("start_timeout", 32'd0, 32'd1);
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic directed(input string tag, input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] er, input logic ec, input logic ez, input logic eo);
    int lat;
    start(o, x, y);
    wait_done(lat);
    chk({tag, "_lat"}, lat, W);
    chk({tag, "_res"}, result, er);
    chk({tag, "_cout"}, cout, ec);
    chk({tag, "_zero"}, zero, ez);
    chk({tag, "_ovf"}, ovf, eo);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_idle"}, {in_ready, out_valid, busy}, 3'b100);
  endtask

  initial begin
    int lat;
    int cyc;
    int last_acc;
    int ndone;
    bit acc;
    bit hs;
    logic [W+2:0] got;
    logic [W+2:0] exp_q[$];

    #12;
    chk("rst_outs", {out_valid, busy, cout, zero, ovf, result}, '0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", in_ready, 1'b1);

    directed("inc_ff", 2'b00, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0);

    // Abort mid-RUN: outputs clear immediately, no result escapes.
    start(2'b10, 8'h12, 8'h34);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_clear", {out_valid, busy, cout, zero, ovf, result}, '0);
    repeat (2) @(posedge clk);
    #1;
    chk("abort_no_valid", out_valid, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    directed("add_1_1", 2'b10, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0);

    directed("inc_7f", 2'b00, 8'h7F, 8'h00, 8'h80, 1'b0, 1'b0, OVF_ON);
    directed("sub_5_7", 2'b11, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0, 1'b0);
    directed("dec_80", 2'b01, 8'h80, 8'h00, 8'h7F, 1'b1, 1'b0, OVF_ON);

    // Stall in DONE with ignored requests arriving.
    start(2'b10, 8'h3C, 8'h44);
    wait_done(lat);
    chk("stall_lat", lat, W);
    for (int i = 0; i < 5; i++) begin
      chk("stall_hold", {out_valid, in_ready, busy, ovf, cout, zero, result},
          {1'b1, 1'b0, 1'b0, OVF_ON, 1'b0, 1'b0, 8'h80});
      in_valid = i[0];
      op = 2'b00; a = 8'h00; b = 8'h00;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("stall_release", {in_ready, out_valid, busy}, 3'b100);
    @(posedge clk); #1;
    chk("stall_no_accept", busy, 1'b0);

    // Back-to-back random ops against the reference model.
    cyc = 0; last_acc = -1; ndone = 0;
    op = 2'($urandom_range(3)); a = W'($urandom); b = W'($urandom);
    in_valid = 1'b1; out_ready = 1'b1;
    while (ndone < 1000 && cyc < 30000) begin
      acc = in_valid && in_ready;
      hs  = out_valid && out_ready;
      got = {ovf, zero, cout, result};
      @(posedge clk); #1;
      cyc++;
      if (hs) begin
        if (exp_q.size() == 0) chk("rnd_unexpected", 32'd1, 32'd0);
        else chk("rnd_result", got, exp_q.pop_front());
        ndone++;
      end
      if (acc) begin
        if (last_acc >= 0) chk("rnd_spacing", cyc - last_acc, W + 2);
        last_acc = cyc;
        exp_q.push_back(model(op, a, b));
        op = 2'($urandom_range(3)); a = W'($urandom); b = W'($urandom);
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("rnd_count", ndone, 1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
